adder_nnbit_ahead_pipe: RTL and testbench
=========================================

ADDER_NNBIT_AHEAD_PIPE -- requirements
Module: adder_nnbit_ahead_pipe

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 16, operand/result width in bits, a multiple of 4.
REQ-002 The block SHALL expose parameter STAGES, default 2, the pipeline depth; (DATA_WIDTH/4) SHALL be divisible by STAGES.
REQ-003 The block SHALL have port i_clk, input, 1, the single clock; all flops rise on its posedge.
REQ-004 The block SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port i_vld, input, 1, upstream operands valid.
REQ-006 The block SHALL have port o_rdy, output, 1, block can accept operands this cycle.
REQ-007 The block SHALL have ports i_num_a and i_num_b, input, DATA_WIDTH, operands a and b.
REQ-008 The block SHALL have port i_cry, input, 1, carry into bit 0.
REQ-009 The block SHALL have port o_vld, output, 1, result valid.
REQ-010 The block SHALL have port i_rdy, input, 1, downstream accepts the result.
REQ-011 The block SHALL have port o_res, output, DATA_WIDTH, sum.
REQ-012 The block SHALL have port o_cry, output, 1, carry out of the MSB.
REQ-013 The block SHALL have port o_ovf, output, 1, two's-complement signed overflow.

Function
REQ-014 Each stage SHALL add a slice of W = DATA_WIDTH/STAGES bits as 4-bit carry-lookahead groups rippling group to group: stage 0 takes bits [W-1:0] with i_cry; stage k takes bits [(k+1)W-1:kW] with the registered carry of stage k-1.
REQ-015 Operand bits not yet consumed and result bits already produced SHALL be carried forward in per-stage registers; this alignment SHALL be kept for every transaction.
REQ-016 A transfer SHALL occur on a cycle with i_vld && o_rdy on input, and with o_vld && i_rdy on output.
REQ-017 Latency from an input transfer to o_vld SHALL be exactly STAGES cycles when no stall occurs.
REQ-018 Each stage SHALL hold a valid bit; stage k SHALL advance when it is empty or stage k+1 (or the output, for the last stage) accepts in the same cycle; o_rdy = !vld[0] || advance[0].
REQ-019 Sustained throughput SHALL be one transaction per cycle while i_rdy=1.
REQ-020 While o_vld=1 and i_rdy=0, o_res, o_cry and o_ovf SHALL stay stable, and no stored transaction SHALL be lost or overwritten.
REQ-021 At most STAGES transactions SHALL be in flight; with the pipeline full and i_rdy=0, o_rdy SHALL be 0.
REQ-022 A simultaneous input transfer and output transfer on a full pipeline SHALL both complete in that cycle.
REQ-023 o_cry SHALL be the carry out of bit DATA_WIDTH-1; o_ovf SHALL be (a[MSB]==b'[MSB]) && (res[MSB]!=a[MSB]), where b' is the operand actually added.
REQ-024 Results SHALL leave in input order.

Reset
REQ-025 While i_rst_n=0, all stage valid bits, o_vld, o_res, o_cry and o_ovf SHALL be 0, asynchronously.
REQ-026 o_rdy SHALL be 1 while in reset and on the first cycle after reset release.
REQ-027 Reset asserted mid-operation SHALL discard every in-flight transaction; no result from before reset SHALL appear afterwards.

Configuration
REQ-028 Macro ADDER_NNBIT_AHEAD_PIPE_SUB_EN, when defined, SHALL add port i_sub, input, 1, sampled with the operands.
REQ-029 With the macro defined and i_sub=1, the block SHALL compute a + ~b + 1 and ignore i_cry; o_cry=1 SHALL mean no borrow.
REQ-030 With the macro defined and i_sub=0, or with the macro undefined, the block SHALL compute a + b + i_cry.
REQ-031 With the macro undefined, port i_sub SHALL not exist and the behaviour SHALL be otherwise identical.

Verification (DATA_WIDTH=16, STAGES=2)
REQ-032 Single add: a=0x00FF, b=0x0001, i_cry=0, i_rdy=1 -> 2 cycles later o_vld=1, o_res=0x0100, o_cry=0, o_ovf=0.
REQ-033 Carry and overflow: 0xFFFF+0x0001 -> o_res=0x0000, o_cry=1, o_ovf=0; 0x7FFF+0x0001 -> o_res=0x8000, o_cry=0, o_ovf=1.
REQ-034 Streaming: four back-to-back transfers (1+1, 2+2, 3+3, 4+4) with i_rdy=1 -> o_vld high on 4 consecutive cycles with o_res 2, 4, 6, 8 in order.
REQ-035 Backpressure: i_rdy=0 while offering 5 transactions -> exactly 2 accepted, then o_rdy=0 and o_res held at the first result; raise i_rdy -> all results drain in order with none lost or duplicated.
REQ-036 Reset mid-flight: assert i_rst_n=0 one cycle after an input transfer -> o_vld=0 immediately and stays 0 after release until a new transfer.
REQ-037 With SUB_EN: a=0x0005, b=0x0007, i_sub=1 -> o_res=0xFFFE, o_cry=0; a=0x0007, b=0x0005 -> o_res=0x0002, o_cry=1.

Source files
------------

// File: rtl/adder_nnbit_ahead_pipe.sv
// Pipelined adder with valid/ready flow: each stage adds one slice using 4-bit CLA groups.
// Define ADDER_NNBIT_AHEAD_PIPE_SUB_EN to add the i_sub port (a + ~b + 1).
module adder_nnbit_ahead_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int STAGES     = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_vld,
  output logic                  o_rdy,
  input  logic [DATA_WIDTH-1:0] i_num_a,
  input  logic [DATA_WIDTH-1:0] i_num_b,
  input  logic                  i_cry,
`ifdef ADDER_NNBIT_AHEAD_PIPE_SUB_EN
  input  logic                  i_sub,
`endif
  output logic                  o_vld,
  input  logic                  i_rdy,
  output logic [DATA_WIDTH-1:0] o_res,
  output logic                  o_cry,
  output logic                  o_ovf
);

  localparam int W = DATA_WIDTH / STAGES;
  localparam int G = W / 4;
  localparam int M = DATA_WIDTH - 1;

  function automatic logic [4:0] cla4(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       c0
  );
    logic [3:0] p, g;
    logic       c1, c2, c3, c4;
    p  = a ^ b;
    g  = a & b;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0])
       | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1])
       | (p[2] & p[1] & g[0])
       | (p[2] & p[1] & p[0] & c0);
    c4 = g[3] | (p[3] & g[2])
       | (p[3] & p[2] & g[1])
       | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c4, p ^ {c3, c2, c1, c0}};
  endfunction

  logic [DATA_WIDTH-1:0] w_b0;
  logic                  w_c0;
  logic [STAGES-1:0]     w_vld;
  logic [STAGES-1:0]     w_en;

`ifdef ADDER_NNBIT_AHEAD_PIPE_SUB_EN
  assign w_b0 = i_sub ? ~i_num_b : i_num_b;
  assign w_c0 = i_sub ? 1'b1 : i_cry;
`else
  assign w_b0 = i_num_b;
  assign w_c0 = i_cry;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [DATA_WIDTH-1:0] w_a, w_b, w_ri, w_ro;
    logic                  w_ci, w_co, w_vi, w_c;
    logic [4:0]            w_t;
    logic [DATA_WIDTH-1:0] r_a, r_b, r_res;
    logic                  r_cry, r_vld;

    if (k == 0) begin : g_in
      assign w_a  = i_num_a;
      assign w_b  = w_b0;
      assign w_ri = '0;
      assign w_ci = w_c0;
      assign w_vi = i_vld;
    end else begin : g_mid
      assign w_a  = g_stg[k-1].r_a;
      assign w_b  = g_stg[k-1].r_b;
      assign w_ri = g_stg[k-1].r_res;
      assign w_ci = g_stg[k-1].r_cry;
      assign w_vi = g_stg[k-1].r_vld;
    end

    // A stage moves when any later stage has a hole or the sink takes the head.
    assign w_en[k]  = i_rdy | (|(~w_vld >> k));
    assign w_vld[k] = r_vld;

    // Add this stage's slice group by group, merging into the partial result.
    always_comb begin
      w_ro = w_ri;
      w_c  = w_ci;
      w_t  = '0;
      for (int j = 0; j < G; j++) begin
        w_t = cla4(w_a[k*W+4*j +: 4],
                   w_b[k*W+4*j +: 4], w_c);
        w_ro[k*W+4*j +: 4] = w_t[3:0];
        w_c = w_t[4];
      end
      w_co = w_c;
    end

    // Stage register: loads the upstream bundle whenever the stage can advance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_vld <= 1'b0;
        r_a   <= '0;
        r_b   <= '0;
        r_res <= '0;
        r_cry <= 1'b0;
      end else if (w_en[k]) begin
        r_vld <= w_vi;
        r_a   <= w_a;
        r_b   <= w_b;
        r_res <= w_ro;
        r_cry <= w_co;
      end
    end
  end

  logic w_unused;
  assign w_unused = ^{g_stg[STAGES-1].r_a,
                      g_stg[STAGES-1].r_b};

  assign o_rdy = w_en[0];
  assign o_vld = g_stg[STAGES-1].r_vld;
  assign o_res = g_stg[STAGES-1].r_res;
  assign o_cry = g_stg[STAGES-1].r_cry;
  assign o_ovf =
    (g_stg[STAGES-1].r_a[M] == g_stg[STAGES-1].r_b[M]) &&
    (g_stg[STAGES-1].r_res[M] != g_stg[STAGES-1].r_a[M]);

endmodule

// File: tb/tb_adder_nnbit_ahead_pipe.sv
// Bench for adder_nnbit_ahead_pipe (16 bit, 2 stages).
// Scoreboard of arithmetic expectations, random and directed traffic.
module tb_adder_nnbit_ahead_pipe;

  logic        clk = 1'b0;
  logic        rst_n, i_vld, o_rdy, cin, o_vld;
  logic        i_rdy, o_cry, o_ovf, sub;
  logic [15:0] a, b, o_res;

  logic        s_vld, s_rdy, s_cry, s_ovf;
  logic [15:0] s_res;
  logic [17:0] q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  adder_nnbit_ahead_pipe #(
    .DATA_WIDTH(16),
    .STAGES(2)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_vld(i_vld),
    .o_rdy(o_rdy),
    .i_num_a(a),
    .i_num_b(b),
    .i_cry(cin),
`ifdef ADDER_NNBIT_AHEAD_PIPE_SUB_EN
    .i_sub(sub),
`endif
    .o_vld(o_vld),
    .i_rdy(i_rdy),
    .o_res(o_res),
    .o_cry(o_cry),
    .o_ovf(o_ovf)
  );

  function automatic logic [17:0] model(
    input logic [15:0] x,
    input logic [15:0] y,
    input logic        c,
    input logic        s
  );
    logic [15:0] yy;
    int          ci, u, sg;
    yy = s ? ~y : y;
    ci = s ? 1 : int'(c);
    u  = int'(x) + int'(yy) + ci;
    sg = int'($signed(x)) + int'($signed(yy)) + ci;
    return {u[15:0], u >= 65536,
            (sg > 32767) || (sg < -32768)};
  endfunction

  task automatic tick(output bit in_x, output bit out_x);
    @(negedge clk);
    s_vld = o_vld;
    s_rdy = o_rdy;
    s_res = o_res;
    s_cry = o_cry;
    s_ovf = o_ovf;
    in_x  = i_vld && o_rdy;
    out_x = o_vld && i_rdy;
    if (in_x) q.push_back(model(a, b, cin, sub));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bit ix, ox;
    rst_n = 1'b0;
    #3;
    n_tests++;
    if ({o_vld, o_res, o_cry, o_ovf} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outs: got %b/%h/%b/%b want 0/0000/0/0",
               o_vld, o_res, o_cry, o_ovf);
    end
    n_tests++;
    if (o_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_rdy: got %b want 1", o_rdy);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(ix, ox);
    n_tests++;
    if (s_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL rdy_after_release: got %b want 1", s_rdy);
    end
  endtask

  task automatic test_single;
    bit ix, ox;
    int lat;
    logic [17:0] e;
    i_rdy = 1'b1;
    i_vld = 1'b1;
    a = 16'h00FF;
    b = 16'h0001;
    cin = 1'b0;
    tick(ix, ox);
    i_vld = 1'b0;
    n_tests++;
    if (!ix) begin
      n_fail++;
      $display("FAIL single_accept: got 0 want 1");
    end
    lat = 0;
    do begin
      tick(ix, ox);
      lat++;
    end while (!s_vld && lat < 10);
    n_tests++;
    if (lat != 2) begin
      n_fail++;
      $display("FAIL single_latency: got %0d want 2", lat);
    end
    e = {16'h0100, 1'b0, 1'b0};
    n_tests++;
    if ({s_res, s_cry, s_ovf} !== e) begin
      n_fail++;
      $display("FAIL single_result: got %h/%b/%b want 0100/0/0",
               s_res, s_cry, s_ovf);
    end
    if (ox && q.size() > 0) void'(q.pop_front());
  endtask

  task automatic test_carry;
    bit ix, ox;
    int n_out;
    logic [17:0] e;
    n_out = 0;
    i_rdy = 1'b1;
    for (int t = 0; t < 10; t++) begin
      i_vld = (t < 2);
      a = (t == 0) ? 16'hFFFF : 16'h7FFF;
      b = 16'h0001;
      cin = 1'b0;
      tick(ix, ox);
      if (ox) begin
        e = (n_out == 0) ? {16'h0000, 1'b1, 1'b0}
                         : {16'h8000, 1'b0, 1'b1};
        n_tests++;
        if ({s_res, s_cry, s_ovf} !== e) begin
          n_fail++;
          $display("FAIL carry[%0d]: got %h/%b/%b want %h/%b/%b",
                   n_out, s_res, s_cry, s_ovf, e[17:2], e[1], e[0]);
        end
        if (q.size() > 0) void'(q.pop_front());
        n_out++;
      end
    end
    i_vld = 1'b0;
    n_tests++;
    if (n_out != 2) begin
      n_fail++;
      $display("FAIL carry_count: got %0d want 2", n_out);
    end
  endtask

  task automatic test_back_to_back;
    bit ix, ox;
    int n_out, n_in, first, last;
    n_out = 0;
    n_in = 0;
    first = -1;
    last = -1;
    i_rdy = 1'b1;
    for (int t = 0; t < 12; t++) begin
      i_vld = (t < 4);
      a = 16'(t + 1);
      b = 16'(t + 1);
      cin = 1'b0;
      tick(ix, ox);
      if (ix) n_in++;
      if (ox) begin
        if (first < 0) first = t;
        last = t;
        n_tests++;
        if (s_res !== 16'(2 * (n_out + 1))) begin
          n_fail++;
          $display("FAIL stream[%0d]: got %h want %h",
                   n_out, s_res, 16'(2 * (n_out + 1)));
        end
        if (q.size() > 0) void'(q.pop_front());
        n_out++;
      end
    end
    i_vld = 1'b0;
    n_tests++;
    if (n_in != 4 || n_out != 4 || last - first != 3) begin
      n_fail++;
      $display("FAIL stream_shape: got in=%0d out=%0d span=%0d want 4/4/3",
               n_in, n_out, last - first);
    end
  endtask

  task automatic test_backpressure;
    bit ix, ox;
    int n, outs, bad_hold;
    logic [17:0] e;
    n = 0;
    bad_hold = 0;
    i_rdy = 1'b0;
    for (int t = 0; t < 8; t++) begin
      i_vld = (n < 5);
      a = 16'(16'h0010 * (n + 1));
      b = 16'h0003;
      cin = logic'(n % 2);
      tick(ix, ox);
      if (ix) n++;
      if (s_vld && q.size() > 0 && s_res !== q[0][17:2])
        bad_hold++;
    end
    n_tests++;
    if (n != 2) begin
      n_fail++;
      $display("FAIL bp_accepted: got %0d want 2", n);
    end
    n_tests++;
    if (s_rdy !== 1'b0 || s_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_flags: got rdy=%b vld=%b want 0/1", s_rdy, s_vld);
    end
    n_tests++;
    if (bad_hold != 0 || s_res !== 16'h0013) begin
      n_fail++;
      $display("FAIL bp_hold: got %h (%0d bad) want 0013", s_res, bad_hold);
    end
    i_rdy = 1'b1;
    outs = 0;
    for (int t = 0; t < 30 && outs < 5; t++) begin
      i_vld = (n < 5);
      a = 16'(16'h0010 * (n + 1));
      b = 16'h0003;
      cin = logic'(n % 2);
      tick(ix, ox);
      if (ix) n++;
      if (ox) begin
        e = (q.size() > 0) ? q.pop_front() : 18'h3FFFF;
        n_tests++;
        if ({s_res, s_cry, s_ovf} !== e) begin
          n_fail++;
          $display("FAIL bp_drain[%0d]: got %h/%b/%b want %h/%b/%b",
                   outs, s_res, s_cry, s_ovf, e[17:2], e[1], e[0]);
        end
        outs++;
      end
    end
    i_vld = 1'b0;
    n_tests++;
    if (outs != 5 || q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_count: got %0d left=%0d want 5/0", outs, q.size());
    end
  endtask

  task automatic test_reset_mid;
    bit ix, ox;
    int lat, stray;
    i_rdy = 1'b0;
    for (int t = 0; t < 2; t++) begin
      i_vld = 1'b1;
      a = 16'($urandom);
      b = 16'($urandom);
      cin = 1'b1;
      tick(ix, ox);
    end
    i_vld = 1'b0;
    n_tests++;
    if (o_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: got vld=%b want 1", o_vld);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (o_vld !== 1'b0 || o_res !== 16'h0 || o_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_async: got vld=%b res=%h rdy=%b want 0/0000/1",
               o_vld, o_res, o_rdy);
    end
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    i_rdy = 1'b1;
    stray = 0;
    for (int t = 0; t < 6; t++) begin
      tick(ix, ox);
      if (s_vld) stray++;
    end
    n_tests++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL rstmid_stray: got %0d valid cycles want 0", stray);
    end
    i_vld = 1'b1;
    a = 16'h1234;
    b = 16'h1111;
    cin = 1'b0;
    tick(ix, ox);
    i_vld = 1'b0;
    lat = 0;
    do begin
      tick(ix, ox);
      lat++;
    end while (!s_vld && lat < 10);
    n_tests++;
    if (!s_vld || s_res !== 16'h2345) begin
      n_fail++;
      $display("FAIL rstmid_new: got vld=%b res=%h want 1/2345", s_vld, s_res);
    end
    if (ox && q.size() > 0) void'(q.pop_front());
  endtask

`ifdef ADDER_NNBIT_AHEAD_PIPE_SUB_EN
  task automatic test_sub;
    bit ix, ox;
    int n_out;
    logic [16:0] e;
    n_out = 0;
    i_rdy = 1'b1;
    for (int t = 0; t < 10; t++) begin
      i_vld = (t < 2);
      sub = 1'b1;
      a = (t == 0) ? 16'h0005 : 16'h0007;
      b = (t == 0) ? 16'h0007 : 16'h0005;
      cin = 1'b0;
      tick(ix, ox);
      if (ox) begin
        e = (n_out == 0) ? {16'hFFFE, 1'b0} : {16'h0002, 1'b1};
        n_tests++;
        if ({s_res, s_cry} !== e) begin
          n_fail++;
          $display("FAIL sub[%0d]: got %h/%b want %h/%b",
                   n_out, s_res, s_cry, e[16:1], e[0]);
        end
        if (q.size() > 0) void'(q.pop_front());
        n_out++;
      end
    end
    i_vld = 1'b0;
    sub = 1'b0;
    n_tests++;
    if (n_out != 2) begin
      n_fail++;
      $display("FAIL sub_count: got %0d want 2", n_out);
    end
  endtask
`endif

  task automatic test_random;
    bit ix, ox;
    bit p_hold;
    logic [17:0] p_out, e;
    logic rdy_now;
    int n_out;
    p_hold = 1'b0;
    p_out = '0;
    n_out = 0;
    for (int t = 0; t < 1500; t++) begin
      i_vld = ($urandom_range(3) != 0);
      rdy_now = ($urandom_range(3) != 0);
      i_rdy = rdy_now;
      a = 16'($urandom);
      b = 16'($urandom);
      cin = 1'($urandom);
`ifdef ADDER_NNBIT_AHEAD_PIPE_SUB_EN
      sub = 1'($urandom);
`endif
      tick(ix, ox);
      if (p_hold) begin
        n_tests++;
        if (!s_vld || {s_res, s_cry, s_ovf} !== p_out) begin
          n_fail++;
          $display("FAIL rnd_stable@%0d: got %b/%h want 1/%h",
                   t, s_vld, {s_res, s_cry, s_ovf}, p_out);
        end
      end
      if (ox) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_extra@%0d: got %h want nothing", t, s_res);
        end else begin
          e = q.pop_front();
          if ({s_res, s_cry, s_ovf} !== e) begin
            n_fail++;
            $display("FAIL rnd_result[%0d]: got %h/%b/%b want %h/%b/%b",
                     n_out, s_res, s_cry, s_ovf, e[17:2], e[1], e[0]);
          end
        end
        n_out++;
      end
      p_hold = s_vld && !rdy_now;
      p_out = {s_res, s_cry, s_ovf};
    end
    i_vld = 1'b0;
    i_rdy = 1'b1;
    sub = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick(ix, ox);
      if (ox) begin
        n_tests++;
        e = (q.size() > 0) ? q.pop_front() : 18'h3FFFF;
        if ({s_res, s_cry, s_ovf} !== e) begin
          n_fail++;
          $display("FAIL rnd_drain: got %h want %h",
                   {s_res, s_cry, s_ovf}, e);
        end
      end
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL rnd_lost: got %0d pending want 0", q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_vld = 1'b0;
    i_rdy = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    test_reset;
    test_single;
    test_carry;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
`ifdef ADDER_NNBIT_AHEAD_PIPE_SUB_EN
    test_sub;
`endif
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
